// File: rtl/apb_completer_pkg.sv
// Shared APB bridge types: completer FSM states, response codes and the request bundle
// that the bridge's APB requester also uses.
package bridge_utils;

   typedef enum logic {
      A_IDLE,
      A_ACCESS
   } apb_state_t;

   localparam logic APB_RESP_OKAY = 1'b0;
   localparam logic APB_RESP_ERR  = 1'b1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        write;
   } apb_req_t;

endpackage

// File: rtl/apb_completer_regfile.sv
// NUM_WORDS x 32 register storage with a byte-strobed write port, a combinational
// read port and an asynchronous clear.
module apb_completer_regfile #(
   parameter int NUM_WORDS = 16,
   parameter int IDX_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [3:0]       wstrb,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [NUM_WORDS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < NUM_WORDS; w++) mem[w] <= '0;
      end else if (we) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
               for (int b = 0; b < 4; b++) begin
                  if (wstrb[b]) mem[w][8*b +: 8] <= wdata[8*b +: 8];
               end
            end
         end
      end
   end

   // Loop compare keeps an idx beyond NUM_WORDS-1 from indexing outside the array.
   always_comb begin
      rdata = '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
         if (idx == IDX_W'(w)) rdata = mem[w];
      end
   end

endmodule

// File: rtl/apb_completer.sv
// APB4 completer with a word-addressed register file and WAIT_CYCLES wait states.
// Define APB_SLVERR_EN to report invalid addresses on pslverr_o (otherwise tied 0).
//
// state    | meaning
// A_IDLE   | no transfer in progress; waiting for a setup cycle
// A_ACCESS | access phase; wait counter runs down, completes at zero
module apb_completer
   import bridge_utils::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_WORDS   = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   input  logic [DATA_WIDTH-1:0] pwdata_i,
   input  logic [3:0]            pstrb_i,
   output logic                  pready_o,
   output logic [DATA_WIDTH-1:0] prdata_o,
   output logic                  pslverr_o
);

   localparam int         LOG_W   = $clog2(NUM_WORDS);
   localparam int         IDX_W   = (LOG_W > 0) ? LOG_W : 1;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   apb_state_t            state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      idx;
   logic                  addr_invalid;
   logic                  we;
   logic [31:0]           rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= A_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         A_IDLE: begin
            if (psel_i && !penable_i) begin
               state_nxt = A_ACCESS;
               cnt_nxt   = WAIT_LD;
            end
         end
         A_ACCESS: begin
            if (!psel_i) begin
               state_nxt = A_IDLE;
               cnt_nxt   = '0;
            end else if (penable_i) begin
               if (cnt != '0) cnt_nxt   = cnt - 4'd1;
               else           state_nxt = A_IDLE;
            end
         end
         default: begin
            state_nxt = A_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // BASE_ADDR is aligned to the window size, so any address below the base wraps
   // to a large offset and every out-of-window address has a nonzero upper offset bit.
   assign offset       = paddr_i - BASE_ADDR;
   assign addr_invalid = (|offset[ADDR_WIDTH-1:LOG_W+2]) | (|offset[1:0]);
   assign idx          = offset[IDX_W+1:2];

   assign pready_o = (state == A_ACCESS) & psel_i & penable_i & (cnt == '0);
   assign we       = pready_o & pwrite_i & ~addr_invalid;
   assign prdata_o = (pready_o & ~pwrite_i & ~addr_invalid) ? DATA_WIDTH'(rdata) : '0;

`ifdef APB_SLVERR_EN
   assign pslverr_o = (pready_o & addr_invalid) ? APB_RESP_ERR : APB_RESP_OKAY;
`else
   assign pslverr_o = APB_RESP_OKAY;
`endif

   apb_completer_regfile #(
      .NUM_WORDS (NUM_WORDS),
      .IDX_W     (IDX_W)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .idx   (idx),
      .wstrb (pstrb_i),
      .wdata (pwdata_i[31:0]),
      .rdata (rdata)
   );

endmodule
